// File: rtl/bsc_axiu_pkg.sv
// Shared widths, FSM state encoding and beat payload for the AXI-Stream utility blocks.
package bsc_axiu_pkg;

    localparam int AXIU_DATA_W = 64;
    localparam int AXIU_TID_W  = 1;
    localparam int AXIU_BEAT_W = AXIU_DATA_W + AXIU_TID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [AXIU_DATA_W-1:0] tdata;
        logic [AXIU_TID_W-1:0]  tid;
        logic                   tlast;
    } axiu_beat_t;

endpackage

// File: rtl/bsc_axiu_axis_skid_buf.sv
// Two-entry strict-FIFO skid buffer carrying data+tid+tlast beats.
// Latency: 1 cycle from push to out_vld; push and pop may coincide while one entry is held.
// Backpressure: in_rdy is registered occupancy (not full) and never depends on out_rdy.
module bsc_axiu_axis_skid_buf
    import bsc_axiu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [AXIU_BEAT_W-1:0] in_dat,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [AXIU_BEAT_W-1:0] out_dat
);

    logic [AXIU_BEAT_W-1:0] mem [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;
    logic                   push;
    logic                   pop;

    // Both handshakes are forced low while rst is held so nothing escapes during reset.
    assign in_rdy  = !rst && (count != 2'd2);
    assign out_vld = !rst && (count != 2'd0);
    assign out_dat = out_vld ? mem[rd_ptr] : '0;

    assign push = in_vld && in_rdy;
    assign pop  = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_dat;
        end
    end

endmodule

// File: rtl/bsc_axiu_axis_tid_arb_mux.sv
// Packet-granular round-robin merge of two AXI-Stream sources, tagging beats with m_tid.
// Latency: 1 cycle from source acceptance to m_tvalid; sustains 1 beat/cycle.
// Backpressure: only the granted source sees tready, driven by registered skid-buffer space.
// Optional per-source packet counters: define BSC_AXIU_TID_MUX_PKT_CNT_EN.
module bsc_axiu_axis_tid_arb_mux
    import bsc_axiu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXIU_DATA_W-1:0] s0_tdata,
    input  logic                   s0_tlast,
    input  logic                   s0_tvalid,
    output logic                   s0_tready,
    input  logic [AXIU_DATA_W-1:0] s1_tdata,
    input  logic                   s1_tlast,
    input  logic                   s1_tvalid,
    output logic                   s1_tready,
    output logic [AXIU_DATA_W-1:0] m_tdata,
    output logic [AXIU_TID_W-1:0]  m_tid,
    output logic                   m_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready
`ifdef BSC_AXIU_TID_MUX_PKT_CNT_EN
    ,
    output logic [31:0]            pkt_cnt0,
    output logic [31:0]            pkt_cnt1
`endif
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       rr_ptr;
    logic       grant_vld;
    logic       grant_src;
    logic       sel_vld;
    logic       sel_last;
    logic       buf_in_vld;
    logic       buf_in_rdy;
    logic       push;
    axiu_beat_t in_beat;
    axiu_beat_t out_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (push && !sel_last) begin
                    state_nxt = grant_src ? ST_LOCK1 : ST_LOCK0;
                end
            end
            ST_LOCK0, ST_LOCK1: begin
                if (push && sel_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rr_ptr holds the last source granted a first beat; its complement wins a tie.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s0_tvalid && s1_tvalid) begin
                    grant_vld = 1'b1;
                    grant_src = ~rr_ptr;
                end else if (s0_tvalid) begin
                    grant_vld = 1'b1;
                    grant_src = 1'b0;
                end else if (s1_tvalid) begin
                    grant_vld = 1'b1;
                    grant_src = 1'b1;
                end
            end
            ST_LOCK0: begin
                grant_vld = 1'b1;
                grant_src = 1'b0;
            end
            ST_LOCK1: begin
                grant_vld = 1'b1;
                grant_src = 1'b1;
            end
            default: begin
                grant_vld = 1'b0;
                grant_src = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b1;
        end else if (state == ST_IDLE && push) begin
            rr_ptr <= grant_src;
        end
    end

    assign sel_vld  = grant_src ? s1_tvalid : s0_tvalid;
    assign sel_last = grant_src ? s1_tlast  : s0_tlast;

    assign s0_tready  = grant_vld && !grant_src && buf_in_rdy;
    assign s1_tready  = grant_vld &&  grant_src && buf_in_rdy;
    assign buf_in_vld = grant_vld && sel_vld;
    assign push       = buf_in_vld && buf_in_rdy;

    assign in_beat.tdata = grant_src ? s1_tdata : s0_tdata;
    assign in_beat.tid   = grant_src;
    assign in_beat.tlast = sel_last;

    bsc_axiu_axis_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (buf_in_vld),
        .in_rdy  (buf_in_rdy),
        .in_dat  (in_beat),
        .out_vld (m_tvalid),
        .out_rdy (m_tready),
        .out_dat (out_beat)
    );

    assign m_tdata = out_beat.tdata;
    assign m_tid   = out_beat.tid;
    assign m_tlast = out_beat.tlast;

`ifdef BSC_AXIU_TID_MUX_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt0 <= 32'd0;
            pkt_cnt1 <= 32'd0;
        end else if (push && sel_last) begin
            if (grant_src) begin
                pkt_cnt1 <= pkt_cnt1 + 32'd1;
            end else begin
                pkt_cnt0 <= pkt_cnt0 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsc_axiu_axis_tid_arb_mux.sv
// Directed bench for the two-source packet arbiter mux; expected values are hand-computed per cycle.
module tb_bsc_axiu_axis_tid_arb_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s0_tdata;
    logic        s0_tlast;
    logic        s0_tvalid;
    logic        s0_tready;
    logic [63:0] s1_tdata;
    logic        s1_tlast;
    logic        s1_tvalid;
    logic        s1_tready;
    logic [63:0] m_tdata;
    logic [0:0]  m_tid;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
`ifdef BSC_AXIU_TID_MUX_PKT_CNT_EN
    logic [31:0] pkt_cnt0;
    logic [31:0] pkt_cnt1;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bsc_axiu_axis_tid_arb_mux dut (
        .clk       (clk),
        .rst       (rst),
        .s0_tdata  (s0_tdata),
        .s0_tlast  (s0_tlast),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s1_tdata  (s1_tdata),
        .s1_tlast  (s1_tlast),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .m_tdata   (m_tdata),
        .m_tid     (m_tid),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready)
`ifdef BSC_AXIU_TID_MUX_PKT_CNT_EN
        ,
        .pkt_cnt0  (pkt_cnt0),
        .pkt_cnt1  (pkt_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle of inputs, then let combinational outputs settle before checking.
    task automatic drv(input logic v0, input logic [63:0] d0, input logic l0,
                       input logic v1, input logic [63:0] d1, input logic l1,
                       input logic mr);
        s0_tvalid = v0; s0_tdata = d0; s0_tlast = l0;
        s1_tvalid = v1; s1_tdata = d1; s1_tlast = l1;
        m_tready  = mr;
        #1;
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, ".s0_tready"}, {63'd0, s0_tready}, {63'd0, r0});
        chk({tag, ".s1_tready"}, {63'd0, s1_tready}, {63'd0, r1});
    endtask

    task automatic chk_m(input string tag, input logic v, input logic [63:0] d,
                         input logic id, input logic l);
        chk({tag, ".m_tvalid"}, {63'd0, m_tvalid}, {63'd0, v});
        if (v) begin
            chk({tag, ".m_tdata"}, m_tdata, d);
            chk({tag, ".m_tid"},   {63'd0, m_tid}, {63'd0, id});
            chk({tag, ".m_tlast"}, {63'd0, m_tlast}, {63'd0, l});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        tick();
        // Sources valid while reset held: no handshake and zeroed outputs.
        drv(1'b1, 64'hFF, 1'b0, 1'b1, 64'hEE, 1'b0, 1'b1);
        chk_rdy("rst", 1'b0, 1'b0);
        chk("rst.m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst.m_tdata", m_tdata, 64'd0);
        chk("rst.m_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst.m_tid", {63'd0, m_tid}, 64'd0);
        tick();
        rst = 1'b0;

        // Single s0 3-beat packet, 1-cycle latency and 1 beat/cycle.
        drv(1'b1, 64'hA0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t1c0", 1'b1, 1'b0);
        chk_m("t1c0", 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 64'hA1, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t1c1", 1'b1, 1'b0);
        chk_m("t1c1", 1'b1, 64'hA0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 64'hA2, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_m("t1c2", 1'b1, 64'hA1, 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_m("t1c3", 1'b1, 64'hA2, 1'b0, 1'b1);
        tick();
        chk_m("t1c4", 1'b0, 64'd0, 1'b0, 1'b0);

        // Contention from reset: s0 packet first, then s1, then s0 wins the next tie.
        do_reset();
        drv(1'b1, 64'hB0, 1'b0, 1'b1, 64'hC0, 1'b0, 1'b1);
        chk_rdy("t2c0", 1'b1, 1'b0);
        tick();
        drv(1'b1, 64'hB1, 1'b1, 1'b1, 64'hC0, 1'b0, 1'b1);
        chk_rdy("t2c1", 1'b1, 1'b0);
        chk_m("t2c1", 1'b1, 64'hB0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b1, 64'hC0, 1'b0, 1'b1);
        chk_rdy("t2c2", 1'b0, 1'b1);
        chk_m("t2c2", 1'b1, 64'hB1, 1'b0, 1'b1);
        tick();
        drv(1'b1, 64'hD0, 1'b1, 1'b1, 64'hC1, 1'b1, 1'b1);
        chk_rdy("t2c3", 1'b0, 1'b1);
        chk_m("t2c3", 1'b1, 64'hC0, 1'b1, 1'b0);
        tick();
        drv(1'b1, 64'hD0, 1'b1, 1'b1, 64'hE0, 1'b1, 1'b1);
        chk_rdy("t2c4", 1'b1, 1'b0);
        chk_m("t2c4", 1'b1, 64'hC1, 1'b1, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b1, 64'hE0, 1'b1, 1'b1);
        chk_rdy("t2c5", 1'b0, 1'b1);
        chk_m("t2c5", 1'b1, 64'hD0, 1'b0, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_m("t2c6", 1'b1, 64'hE0, 1'b1, 1'b1);
        tick();
        chk_m("t2c7", 1'b0, 64'd0, 1'b0, 1'b0);

        // s1 locked mid-packet with a gap; s0 must wait for the s1 tlast beat.
        drv(1'b0, 64'd0, 1'b0, 1'b1, 64'hF0, 1'b0, 1'b1);
        chk_rdy("t3c0", 1'b0, 1'b1);
        tick();
        drv(1'b1, 64'h60, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t3c1", 1'b0, 1'b1);
        chk_m("t3c1", 1'b1, 64'hF0, 1'b1, 1'b0);
        tick();
        drv(1'b1, 64'h60, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t3c2", 1'b0, 1'b1);
        chk_m("t3c2", 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 64'h60, 1'b1, 1'b1, 64'hF1, 1'b1, 1'b1);
        chk_rdy("t3c3", 1'b0, 1'b1);
        tick();
        drv(1'b1, 64'h60, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t3c4", 1'b1, 1'b0);
        chk_m("t3c4", 1'b1, 64'hF1, 1'b1, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_m("t3c5", 1'b1, 64'h60, 1'b0, 1'b1);
        tick();
        chk_m("t3c6", 1'b0, 64'd0, 1'b0, 1'b0);

        // Downstream stall for 4 cycles: two beats buffered, then drained in order.
        drv(1'b1, 64'h70, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk_rdy("t4c0", 1'b1, 1'b0);
        chk_m("t4c0", 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 64'h71, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0);
        chk_rdy("t4c1", 1'b1, 1'b0);
        chk_m("t4c1", 1'b1, 64'h70, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 64'h72, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0);
            chk_rdy("t4full", 1'b0, 1'b0);
            chk_m("t4full", 1'b1, 64'h70, 1'b0, 1'b0);
            tick();
        end
        drv(1'b1, 64'h72, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t4c4", 1'b0, 1'b0);
        chk_m("t4c4", 1'b1, 64'h70, 1'b0, 1'b0);
        tick();
        drv(1'b1, 64'h72, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t4c5", 1'b1, 1'b0);
        chk_m("t4c5", 1'b1, 64'h71, 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_m("t4c6", 1'b1, 64'h72, 1'b0, 1'b1);
        tick();
        chk_m("t4c7", 1'b0, 64'd0, 1'b0, 1'b0);

        // Reset in the middle of an s1 packet drops the buffer and lock.
        drv(1'b0, 64'd0, 1'b0, 1'b1, 64'h90, 1'b0, 1'b1);
        chk_rdy("t5c0", 1'b0, 1'b1);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b1, 64'h91, 1'b0, 1'b1);
        chk_m("t5c1", 1'b1, 64'h90, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        drv(1'b0, 64'd0, 1'b0, 1'b1, 64'h92, 1'b0, 1'b1);
        chk_rdy("t5rst", 1'b0, 1'b0);
        chk_m("t5rst", 1'b0, 64'd0, 1'b0, 1'b0);
        chk("t5rst.m_tdata", m_tdata, 64'd0);
        tick();
        rst = 1'b0;
        drv(1'b1, 64'h80, 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_rdy("t5c3", 1'b1, 1'b0);
        chk_m("t5c3", 1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk_m("t5c4", 1'b1, 64'h80, 1'b0, 1'b1);
        tick();
        chk_m("t5c5", 1'b0, 64'd0, 1'b0, 1'b0);

`ifdef BSC_AXIU_TID_MUX_PKT_CNT_EN
        do_reset();
        chk("cnt.rst0", {32'd0, pkt_cnt0}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 64'(i), 1'b1, 1'b0, 64'd0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drv(1'b0, 64'd0, 1'b0, 1'b1, 64'(i), 1'b1, 1'b1);
            tick();
        end
        drv(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        chk("cnt.pkt_cnt0", {32'd0, pkt_cnt0}, 64'd5);
        chk("cnt.pkt_cnt1", {32'd0, pkt_cnt1}, 64'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
